// File: rtl/clock_period_meter.sv
// clock_period_meter
//   Measures a slow, asynchronous signal in units of clk_in cycles. For every
//   full cycle of sig_in (rising edge to rising edge) it reports the period
//   and the number of cycles sig_in was high, and flags a timeout when no
//   rising edge arrives for TIMEOUT_CYCLES cycles.
//
// Ports
//   clk_in     in   measurement clock, all logic on posedge
//   rst        in   synchronous, active-high reset
//   enable     in   1 = measure, 0 = return to idle
//   sig_in     in   signal under test, asynchronous to clk_in
//   period     out  clk_in cycles between the last two rising edges
//   high_time  out  clk_in cycles sig_in was high within that period
//   meas_valid out  one-cycle pulse when period/high_time update
//   timeout    out  level, no rising edge seen for TIMEOUT_CYCLES cycles
module clock_period_meter #(
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 meas_valid,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] TOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_TOUT    = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 s1_q, s1_d;
  logic                 s2_q, s2_d;
  logic                 s3_q, s3_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_time_q, high_time_d;
  logic                 meas_valid_q, meas_valid_d;
  logic                 timeout_q, timeout_d;
  logic                 rise;

  // Synchronised rising edge of sig_in
  assign rise = s2_q & ~s3_q;

  // Next-state and counter logic
  always_comb begin
    state_d      = state_q;
    s1_d         = sig_in;
    s2_d         = s1_q;
    s3_d         = s2_q;
    cnt_d        = cnt_q;
    hcnt_d       = hcnt_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = 1'b0;
    timeout_d    = timeout_q;

    if (!enable) begin
      // Disable overrides everything, including a coincident rise
      state_d   = ST_IDLE;
      cnt_d     = CNT_ZERO;
      hcnt_d    = CNT_ZERO;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d     = CNT_ZERO;
          hcnt_d    = CNT_ZERO;
          timeout_d = 1'b0;
          state_d   = ST_ARM;
        end
        ST_ARM: begin
          // First edge only starts counting; it never yields a result
          if (rise) begin
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            // A rise on the timeout cycle still wins
            period_d     = cnt_q;
            high_time_d  = hcnt_q;
            meas_valid_d = 1'b1;
            cnt_d        = CNT_ONE;
            hcnt_d       = CNT_ONE;
          end else if (cnt_q == TOUT_VAL) begin
            timeout_d = 1'b1;
            state_d   = ST_TOUT;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (s2_q) begin
              hcnt_d = hcnt_q + CNT_ONE;
            end
          end
        end
        ST_TOUT: begin
          // The gap is not a valid period: restart without reporting
          if (rise) begin
            timeout_d = 1'b0;
            cnt_d     = CNT_ONE;
            hcnt_d    = CNT_ONE;
            state_d   = ST_MEASURE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      cnt_q        <= CNT_ZERO;
      hcnt_q       <= CNT_ZERO;
      period_q     <= CNT_ZERO;
      high_time_q  <= CNT_ZERO;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      cnt_q        <= cnt_d;
      hcnt_q       <= hcnt_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign meas_valid = meas_valid_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Testbench for clock_period_meter. A cycle-level reference model tracks
// rising edges of the (delayed) input as timestamps and a window of samples,
// and every cycle the DUT outputs are compared with it.
module tb_clock_period_meter;

  localparam int unsigned CW = 32;
  localparam int unsigned TO = 64;

  logic          clk_in;
  logic          rst;
  logic          enable;
  logic          sig_in;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic          timeout;

  clock_period_meter #(
    .CNT_WIDTH      (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .enable     (enable),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .timeout    (timeout)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Reference model state
  logic          m_s1, m_s2, m_s3;
  bit            armed, have_ref, timed_out;
  bit            win[$];
  logic          e_mv, e_to;
  logic [CW-1:0] e_per, e_ht;
  int            n_cmp = 0;
  int            n_bad = 0;

  function automatic logic pat(input int i, input int h, input int l);
    return (i % (h + l)) < h;
  endfunction

  // One clock edge of the model: a result is the distance between two
  // counted rises plus the number of high samples in between.
  task automatic model_edge(input logic r, input logic en, input logic s);
    logic rise;
    int   hs;
    rise = m_s2 & ~m_s3;
    e_mv = 1'b0;
    if (r) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_s3 = 1'b0;
      armed = 0; have_ref = 0; timed_out = 0;
      win.delete();
      e_to = 1'b0; e_per = '0; e_ht = '0;
    end else begin
      if (!en) begin
        armed = 0; have_ref = 0; timed_out = 0;
        win.delete();
        e_to = 1'b0;
      end else if (!armed) begin
        armed = 1;
      end else if (rise) begin
        if (have_ref && !timed_out) begin
          hs = 0;
          for (int k = 0; k < win.size(); k++) if (win[k]) hs++;
          e_per = CW'(win.size());
          e_ht  = CW'(hs);
          e_mv  = 1'b1;
        end
        win.delete();
        win.push_back(1'b1);
        have_ref = 1; timed_out = 0; e_to = 1'b0;
      end else if (have_ref && !timed_out) begin
        if (win.size() == int'(TO)) begin
          timed_out = 1; e_to = 1'b1;
        end else begin
          win.push_back(m_s2);
        end
      end
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = s;
    end
  endtask

  task automatic step(input logic r, input logic en, input logic s);
    rst = r; enable = en; sig_in = s;
    @(posedge clk_in);
    model_edge(r, en, s);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'(i));
      n_cmp++;
      if ({meas_valid, timeout, period, high_time} !== {1'b0, 1'b0, CW'(0), CW'(0)}) begin
        n_bad++;
        $display("FAIL reset cyc=%0d got mv=%b to=%b per=%0d ht=%0d want all zero",
                 i, meas_valid, timeout, period, high_time);
      end
    end
  endtask

  task automatic test_div4();
    int nmv = 0;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 48; i++) begin
      step(1'b0, 1'b1, pat(i, 2, 2));
      n_cmp++;
      if ({meas_valid, timeout, period, high_time} !== {e_mv, e_to, e_per, e_ht}) begin
        n_bad++;
        $display("FAIL div4 cyc=%0d got mv=%b to=%b per=%0d ht=%0d want mv=%b to=%b per=%0d ht=%0d",
                 i, meas_valid, timeout, period, high_time, e_mv, e_to, e_per, e_ht);
      end
      if (meas_valid === 1'b1) begin
        nmv++;
        n_cmp++;
        if (period !== CW'(4) || high_time !== CW'(2)) begin
          n_bad++;
          $display("FAIL div4_value got per=%0d ht=%0d want per=4 ht=2", period, high_time);
        end
      end
    end
    n_cmp++;
    if (nmv < 10) begin
      n_bad++;
      $display("FAIL div4_count got %0d pulses want >=10", nmv);
    end
  endtask

  task automatic test_3h5l();
    int nmv = 0;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 1'b1, pat(i, 3, 5));
      n_cmp++;
      if ({meas_valid, timeout, period, high_time} !== {e_mv, e_to, e_per, e_ht}) begin
        n_bad++;
        $display("FAIL 3h5l cyc=%0d got mv=%b to=%b per=%0d ht=%0d want mv=%b to=%b per=%0d ht=%0d",
                 i, meas_valid, timeout, period, high_time, e_mv, e_to, e_per, e_ht);
      end
      if (meas_valid === 1'b1) begin
        nmv++;
        n_cmp++;
        if (period !== CW'(8) || high_time !== CW'(3)) begin
          n_bad++;
          $display("FAIL 3h5l_value got per=%0d ht=%0d want per=8 ht=3", period, high_time);
        end
      end
    end
    n_cmp++;
    if (nmv < 6) begin
      n_bad++;
      $display("FAIL 3h5l_count got %0d pulses want >=6", nmv);
    end
  endtask

  task automatic test_timeout();
    int   last_mv = -1;
    int   first_to = -1;
    int   post_mv = 0;
    logic s;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 160; i++) begin
      s = (i < 30) ? pat(i, 5, 5) : (i < 120) ? 1'b0 : pat(i - 120, 5, 5);
      step(1'b0, 1'b1, s);
      n_cmp++;
      if ({meas_valid, timeout, period, high_time} !== {e_mv, e_to, e_per, e_ht}) begin
        n_bad++;
        $display("FAIL timeout cyc=%0d got mv=%b to=%b per=%0d ht=%0d want mv=%b to=%b per=%0d ht=%0d",
                 i, meas_valid, timeout, period, high_time, e_mv, e_to, e_per, e_ht);
      end
      if (meas_valid === 1'b1 && i < 120) last_mv = i;
      if (timeout === 1'b1 && first_to < 0) begin
        first_to = i;
        n_cmp++;
        if (period !== CW'(10)) begin
          n_bad++;
          $display("FAIL timeout_hold got per=%0d want 10", period);
        end
      end
      if (meas_valid === 1'b1 && i >= 120) begin
        post_mv++;
        n_cmp++;
        if (post_mv == 1 && (i < 130 || period !== CW'(10) || high_time !== CW'(5))) begin
          n_bad++;
          $display("FAIL timeout_restart cyc=%0d got per=%0d ht=%0d want cyc>=130 per=10 ht=5",
                   i, period, high_time);
        end
      end
    end
    n_cmp++;
    if (first_to - last_mv != int'(TO)) begin
      n_bad++;
      $display("FAIL timeout_delay got %0d want %0d", first_to - last_mv, TO);
    end
    n_cmp++;
    if (timeout !== 1'b0 || post_mv < 2) begin
      n_bad++;
      $display("FAIL timeout_clear got to=%b pulses=%0d want to=0 pulses>=2", timeout, post_mv);
    end
  endtask

  task automatic test_reset_mid();
    int nmv = 0;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 27; i++) begin
      step(1'b0, 1'b1, pat(i, 5, 5));
      n_cmp++;
      if ({meas_valid, timeout, period, high_time} !== {e_mv, e_to, e_per, e_ht}) begin
        n_bad++;
        $display("FAIL rstmid cyc=%0d got mv=%b to=%b per=%0d ht=%0d want mv=%b to=%b per=%0d ht=%0d",
                 i, meas_valid, timeout, period, high_time, e_mv, e_to, e_per, e_ht);
      end
    end
    step(1'b1, 1'b1, pat(27, 5, 5));
    n_cmp++;
    if ({meas_valid, timeout, period, high_time} !== {1'b0, 1'b0, CW'(0), CW'(0)}) begin
      n_bad++;
      $display("FAIL rstmid_zero got mv=%b to=%b per=%0d ht=%0d want all zero",
               meas_valid, timeout, period, high_time);
    end
    for (int i = 28; i < 80; i++) begin
      step(1'b0, 1'b1, pat(i, 5, 5));
      n_cmp++;
      if ({meas_valid, timeout, period, high_time} !== {e_mv, e_to, e_per, e_ht}) begin
        n_bad++;
        $display("FAIL rstmid cyc=%0d got mv=%b to=%b per=%0d ht=%0d want mv=%b to=%b per=%0d ht=%0d",
                 i, meas_valid, timeout, period, high_time, e_mv, e_to, e_per, e_ht);
      end
      if (meas_valid === 1'b1) begin
        nmv++;
        n_cmp++;
        if (period !== CW'(10) || high_time !== CW'(5)) begin
          n_bad++;
          $display("FAIL rstmid_value got per=%0d ht=%0d want per=10 ht=5", period, high_time);
        end
      end
    end
    n_cmp++;
    if (nmv < 3) begin
      n_bad++;
      $display("FAIL rstmid_count got %0d pulses want >=3", nmv);
    end
  endtask

  task automatic test_enable_gap();
    logic en;
    int   nmv_off = 0;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 80; i++) begin
      en = !(i >= 30 && i < 50);
      step(1'b0, en, pat(i, 2, 2));
      n_cmp++;
      if ({meas_valid, timeout, period, high_time} !== {e_mv, e_to, e_per, e_ht}) begin
        n_bad++;
        $display("FAIL engap cyc=%0d got mv=%b to=%b per=%0d ht=%0d want mv=%b to=%b per=%0d ht=%0d",
                 i, meas_valid, timeout, period, high_time, e_mv, e_to, e_per, e_ht);
      end
      if (i > 30 && i <= 50) begin
        if (meas_valid === 1'b1) nmv_off++;
        n_cmp++;
        if (period !== CW'(4)) begin
          n_bad++;
          $display("FAIL engap_hold cyc=%0d got per=%0d want 4", i, period);
        end
      end
    end
    n_cmp++;
    if (nmv_off != 0) begin
      n_bad++;
      $display("FAIL engap_pulses got %0d pulses while disabled want 0", nmv_off);
    end
  endtask

  task automatic test_reset_high();
    int first_mv = -1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b1, pat(i, 3, 3));
      n_cmp++;
      if ({meas_valid, timeout, period, high_time} !== {e_mv, e_to, e_per, e_ht}) begin
        n_bad++;
        $display("FAIL rsthigh cyc=%0d got mv=%b to=%b per=%0d ht=%0d want mv=%b to=%b per=%0d ht=%0d",
                 i, meas_valid, timeout, period, high_time, e_mv, e_to, e_per, e_ht);
      end
      if (meas_valid === 1'b1) begin
        if (first_mv < 0) first_mv = i;
        n_cmp++;
        if (period !== CW'(6) || high_time !== CW'(3)) begin
          n_bad++;
          $display("FAIL rsthigh_value got per=%0d ht=%0d want per=6 ht=3", period, high_time);
        end
      end
    end
    n_cmp++;
    if (first_mv < 6) begin
      n_bad++;
      $display("FAIL rsthigh_first got first pulse at %0d want >=6", first_mv);
    end
  endtask

  task automatic test_random();
    int   hi, lo, cyc;
    logic en, r;
    cyc = 0;
    step(1'b1, 1'b1, 1'b0);
    for (int seg = 0; seg < 100; seg++) begin
      hi = $urandom_range(2, 9);
      lo = ($urandom_range(0, 15) == 0) ? $urandom_range(60, 80) : $urandom_range(2, 9);
      en = ($urandom_range(0, 19) != 0);
      for (int j = 0; j < hi + lo; j++) begin
        r = (j == 0) && ($urandom_range(0, 39) == 0);
        step(r, en, 1'(j < hi));
        cyc++;
        n_cmp++;
        if ({meas_valid, timeout, period, high_time} !== {e_mv, e_to, e_per, e_ht}) begin
          n_bad++;
          $display("FAIL random cyc=%0d got mv=%b to=%b per=%0d ht=%0d want mv=%b to=%b per=%0d ht=%0d",
                   cyc, meas_valid, timeout, period, high_time, e_mv, e_to, e_per, e_ht);
        end
        if (meas_valid === 1'b1) begin
          n_cmp++;
          if (!(high_time < period)) begin
            n_bad++;
            $display("FAIL random_invariant got per=%0d ht=%0d want ht<per", period, high_time);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; sig_in = 1'b0;
    m_s1 = 1'b0; m_s2 = 1'b0; m_s3 = 1'b0;
    e_mv = 1'b0; e_to = 1'b0; e_per = '0; e_ht = '0;
    test_reset();
    test_div4();
    test_3h5l();
    test_timeout();
    test_reset_mid();
    test_enable_gap();
    test_reset_high();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
